// File: rtl/word_pair_sequencer_pkg.sv
// Shared constants and types for the byte-pair feeder of the byte-to-word synchronizer.
// State encodings are fixed so the state register can be probed in bring-up.
package word_pair_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LO = 2'd0,
        WAIT_HI = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam int DEF_TIMEOUT     = 16;
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_CNT_W       = 8;

    // Counters run up from zero, so an N-cycle window ends on count N-1.
    function automatic int term_of(input int n);
        return (n > 0) ? n - 1 : 0;
    endfunction

endpackage

// File: rtl/word_pair_sequencer_if.sv
// Byte-stream handshake plus the strobe bus into the byte-to-word synchronizer.
// The master feeds bytes and observes the strobes; the sequencer is the slave.
interface word_pair_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic       en0;
    logic       en1;
    logic       ld;

    modport master (
        output in_data, in_valid,
        input  in_ready, d, en0, en1, ld
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, d, en0, en1, ld
    );
endinterface

// File: rtl/word_pair_sequencer_cycle_counter.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-count flag.
// Used for both the orphaned-low-byte timeout and the post-load hold-off.
module word_pair_sequencer_cycle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/word_pair_sequencer.sv
// Pairs an incoming byte stream low-then-high and strobes it into the synchronizer,
// with a post-load hold-off and a timeout that discards orphaned low bytes.
module word_pair_sequencer
    import word_pair_sequencer_pkg::*;
#(
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    word_pair_sequencer_if.slave bus,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [7:0]           pair_count
);

    localparam logic [CNT_W-1:0] TO_TERM   = CNT_W'(term_of(TIMEOUT));
    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(term_of(HOLD_CYCLES));

    state_e     state, state_nx;
    logic [7:0] d_q, d_nx;
    logic       en0_q, en0_nx;
    logic       en1_q, en1_nx;
    logic       ld_q, ld_nx;
    logic       err_nx;
    logic [7:0] pc_nx;
    logic       acc;
    logic       to_clr, to_en, to_tc;
    logic       ho_clr, ho_en, ho_tc;

    assign bus.in_ready = ((state == WAIT_LO) || (state == WAIT_HI)) && !clr;
    assign acc          = bus.in_valid && bus.in_ready;
    assign busy         = (state == WAIT_HI) || (state == HOLD);
    assign bus.d        = d_q;
    assign bus.en0      = en0_q;
    assign bus.en1      = en1_q;
    assign bus.ld       = ld_q;

    word_pair_sequencer_cycle_counter #(.CNT_W(CNT_W)) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (to_clr),
        .en    (to_en),
        .term  (TO_TERM),
        .tc    (to_tc)
    );

    word_pair_sequencer_cycle_counter #(.CNT_W(CNT_W)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ho_clr),
        .en    (ho_en),
        .term  (HOLD_TERM),
        .tc    (ho_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_LO;
            d_q         <= 8'h00;
            en0_q       <= 1'b0;
            en1_q       <= 1'b0;
            ld_q        <= 1'b0;
            err_timeout <= 1'b0;
            pair_count  <= 8'h00;
        end else begin
            state       <= state_nx;
            d_q         <= d_nx;
            en0_q       <= en0_nx;
            en1_q       <= en1_nx;
            ld_q        <= ld_nx;
            err_timeout <= err_nx;
            pair_count  <= pc_nx;
        end
    end

    // Strobes default low every cycle so each pulse is exactly one cycle wide.
    always_comb begin
        state_nx = state;
        d_nx     = d_q;
        en0_nx   = 1'b0;
        en1_nx   = 1'b0;
        ld_nx    = 1'b0;
        err_nx   = err_timeout;
        pc_nx    = pair_count;
        to_clr   = 1'b0;
        to_en    = 1'b0;
        ho_clr   = 1'b0;
        ho_en    = 1'b0;
        if (clr) begin
            state_nx = WAIT_LO;
            err_nx   = 1'b0;
            pc_nx    = 8'h00;
            to_clr   = 1'b1;
            ho_clr   = 1'b1;
        end else begin
            case (state)
                WAIT_LO: begin
                    if (acc) begin
                        d_nx     = bus.in_data;
                        en0_nx   = 1'b1;
                        state_nx = WAIT_HI;
                        to_clr   = 1'b1;
                    end
                end
                WAIT_HI: begin
                    // A high byte arriving in the last window cycle beats the timeout.
                    if (acc) begin
                        d_nx     = bus.in_data;
                        en1_nx   = 1'b1;
                        ld_nx    = 1'b1;
                        pc_nx    = pair_count + 8'd1;
                        state_nx = (HOLD_CYCLES == 0) ? WAIT_LO : HOLD;
                        ho_clr   = 1'b1;
                    end else begin
                        to_en = 1'b1;
                        if ((TIMEOUT != 0) && to_tc) begin
                            state_nx = WAIT_LO;
                            err_nx   = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    ho_en = 1'b1;
                    if (ho_tc) begin
                        state_nx = WAIT_LO;
                    end
                end
                default: state_nx = WAIT_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_word_pair_sequencer.sv
// Checks two sequencers (default timing, and zero hold / no timeout) against a
// transaction-level model of pending-byte, wait-time and hold-off bookkeeping.
module tb_word_pair_sequencer;

    localparam int TO_A = 16;
    localparam int HO_A = 4;
    localparam int TO_Z = 0;
    localparam int HO_Z = 0;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clr    = 1'b0;
    logic       tvalid = 1'b0;
    logic [7:0] tdata  = 8'h00;

    always #5 clk = ~clk;

    word_pair_sequencer_if bus_a ();
    word_pair_sequencer_if bus_z ();

    assign bus_a.in_data  = tdata;
    assign bus_a.in_valid = tvalid;
    assign bus_z.in_data  = tdata;
    assign bus_z.in_valid = tvalid;

    logic       busy_a, err_a, busy_z, err_z;
    logic [7:0] pc_a, pc_z;

    word_pair_sequencer #(.TIMEOUT(TO_A), .HOLD_CYCLES(HO_A), .CNT_W(8)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .bus         (bus_a),
        .busy        (busy_a),
        .err_timeout (err_a),
        .pair_count  (pc_a)
    );

    word_pair_sequencer #(.TIMEOUT(TO_Z), .HOLD_CYCLES(HO_Z), .CNT_W(8)) dut_z (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .bus         (bus_z),
        .busy        (busy_z),
        .err_timeout (err_z),
        .pair_count  (pc_z)
    );

    logic [20:0] obs_a, obs_z;
    assign obs_a = {bus_a.d, bus_a.en0, bus_a.en1, bus_a.ld, busy_a, err_a, pc_a};
    assign obs_z = {bus_z.d, bus_z.en0, bus_z.en1, bus_z.ld, busy_z, err_z, pc_z};

    typedef struct {
        bit         pend;
        int         waited;
        int         hold_left;
        logic [7:0] d;
        bit         en0, en1, ld, err;
        logic [7:0] pc;
    } mdl_t;

    mdl_t ma, mz;
    int   errs   = 0;
    int   checks = 0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.pend = 0; m.waited = 0; m.hold_left = 0;
        m.d = 8'h00; m.en0 = 0; m.en1 = 0; m.ld = 0; m.err = 0; m.pc = 8'h00;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int tmo, input int hold,
                                      input bit c, input bit v, input logic [7:0] dat);
        mdl_t n = m;
        n.en0 = 0; n.en1 = 0; n.ld = 0;
        if (c) begin
            n.pend = 0; n.waited = 0; n.hold_left = 0; n.err = 0; n.pc = 8'h00;
        end else if (m.hold_left > 0) begin
            n.hold_left = m.hold_left - 1;
        end else if (v) begin
            n.d = dat;
            if (!m.pend) begin
                n.en0 = 1; n.pend = 1; n.waited = 0;
            end else begin
                n.en1 = 1; n.ld = 1; n.pend = 0;
                n.pc = 8'((int'(m.pc) + 1) % 256);
                n.hold_left = hold;
            end
        end else if (m.pend) begin
            n.waited = m.waited + 1;
            if (tmo != 0 && n.waited == tmo) begin
                n.pend = 0; n.err = 1;
            end
        end
        return n;
    endfunction

    function automatic logic [20:0] mdl_regs(input mdl_t m);
        return {m.d, m.en0, m.en1, m.ld, (m.pend || m.hold_left > 0), m.err, m.pc};
    endfunction

    function automatic logic mdl_ready(input mdl_t m, input bit c);
        return (m.hold_left == 0) && !c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic tick();
        #2;
        chk("ready_a", 32'(bus_a.in_ready), 32'(mdl_ready(ma, clr)));
        chk("ready_z", 32'(bus_z.in_ready), 32'(mdl_ready(mz, clr)));
        ma = mdl_step(ma, TO_A, HO_A, clr, tvalid, tdata);
        mz = mdl_step(mz, TO_Z, HO_Z, clr, tvalid, tdata);
        @(posedge clk);
        #1;
        chk("regs_a", 32'(obs_a), 32'(mdl_regs(ma)));
        chk("regs_z", 32'(obs_z), 32'(mdl_regs(mz)));
    endtask

    task automatic drive(input bit c, input bit v, input logic [7:0] dat);
        clr = c; tvalid = v; tdata = dat;
        tick();
    endtask

    initial begin
        int         low_cnt;
        logic [7:0] lo_cap;

        ma = mdl_reset();
        mz = mdl_reset();
        #12;
        chk("rst_regs_a", 32'(obs_a), 32'(mdl_regs(ma)));
        chk("rst_regs_z", 32'(obs_z), 32'(mdl_regs(mz)));
        chk("rst_d", 32'(bus_a.d), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        repeat (2) drive(0, 0, 8'h00);
        chk("idle_ready", 32'(bus_a.in_ready), 32'd1);
        chk("idle_busy", 32'(busy_a), 32'd0);

        // back-to-back pair, then measure the hold-off window
        drive(0, 1, 8'hA5);
        chk("lo_strobe", 32'({bus_a.d, bus_a.en0, bus_a.ld}), 32'({8'hA5, 1'b1, 1'b0}));
        lo_cap = bus_a.d;
        drive(0, 1, 8'h5A);
        chk("hi_strobe", 32'({bus_a.d, bus_a.en0, bus_a.en1, bus_a.ld}),
            32'({8'h5A, 1'b0, 1'b1, 1'b1}));
        chk("word", 32'({bus_a.d, lo_cap}), 32'h5AA5);
        low_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus_a.in_ready !== 1'b1) low_cnt++;
            drive(0, 0, 8'h00);
        end
        chk("hold_len", 32'(low_cnt), 32'd4);
        chk("pc_one", 32'(pc_a), 32'd1);

        // orphaned low byte times out after 16 idle cycles
        drive(0, 1, 8'hA5);
        repeat (16) drive(0, 0, 8'h00);
        chk("to_err", 32'(err_a), 32'd1);
        chk("to_idle", 32'({busy_a, bus_a.ld}), 32'd0);
        drive(0, 1, 8'h11);
        drive(0, 1, 8'h22);
        chk("to_pair", 32'({bus_a.d, bus_a.ld}), 32'({8'h22, 1'b1}));
        repeat (5) drive(0, 0, 8'h00);

        // high byte in the final window cycle wins
        drive(1, 0, 8'h00);
        drive(0, 1, 8'hA5);
        repeat (15) drive(0, 0, 8'h00);
        drive(0, 1, 8'hC3);
        chk("late_hi", 32'({bus_a.ld, bus_a.en1, err_a}), 32'({1'b1, 1'b1, 1'b0}));
        repeat (5) drive(0, 0, 8'h00);

        // clear while waiting for the high byte
        drive(0, 1, 8'h66);
        clr = 1'b1; tvalid = 1'b1; tdata = 8'h99;
        #1;
        chk("clr_ready", 32'(bus_a.in_ready), 32'd0);
        tick();
        chk("clr_state", 32'(obs_a), 32'({8'h66, 3'b000, 1'b0, 1'b0, 8'h00}));
        drive(0, 0, 8'h00);

        repeat (400) drive($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 8'($urandom));

        // 256 pairs for dut_a (6 cycles each), 768 for dut_z: both counters wrap to 0
        drive(1, 0, 8'h00);
        repeat (1536) drive(0, 1, 8'($urandom));
        chk("wrap_a", 32'(pc_a), 32'd0);
        chk("wrap_z", 32'(pc_z), 32'd0);

        // asynchronous reset mid-pair
        drive(0, 1, 8'h77);
        tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        ma = mdl_reset();
        mz = mdl_reset();
        chk("arst_a", 32'(obs_a), 32'(mdl_regs(ma)));
        chk("arst_z", 32'(obs_z), 32'(mdl_regs(mz)));
        chk("arst_ready", 32'(bus_a.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 1, 8'h12);
        chk("post_rst_lo", 32'({bus_a.d, bus_a.en0, bus_a.ld}), 32'({8'h12, 1'b1, 1'b0}));
        drive(0, 1, 8'h34);
        chk("post_rst_hi", 32'({bus_a.d, bus_a.ld, pc_a}), 32'({8'h34, 1'b1, 8'h01}));
        repeat (6) drive(0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
